// File: rtl/ysyx_22041211_exu_pkg.sv
// rtl/ysyx_22041211_exu_pkg.sv - ALU, operand-select, branch and FSM codes shared by the EXU and its ALU
package ysyx_22041211_exu_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int MEM_OP_W   = 4;

    typedef enum logic [3:0] {
        ALU_OP_ADD           = 4'd0,
        ALU_OP_SUB           = 4'd1,
        ALU_OP_AND           = 4'd2,
        ALU_OP_OR            = 4'd3,
        ALU_OP_XOR           = 4'd4,
        ALU_OP_SLL           = 4'd5,
        ALU_OP_SRL           = 4'd6,
        ALU_OP_SRA           = 4'd7,
        ALU_OP_LESS_SIGNED   = 4'd8,
        ALU_OP_LESS_UNSIGNED = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        SRC1_RS1  = 2'd0,
        SRC1_PC   = 2'd1,
        SRC1_ZERO = 2'd2
    } src1_sel_e;

    typedef enum logic [1:0] {
        SRC2_RS2  = 2'd0,
        SRC2_IMM  = 2'd1,
        SRC2_FOUR = 2'd2
    } src2_sel_e;

    typedef enum logic [3:0] {
        BR_NONE = 4'd0,
        BR_BEQ  = 4'd1,
        BR_BNE  = 4'd2,
        BR_BLT  = 4'd3,
        BR_BGE  = 4'd4,
        BR_BLTU = 4'd5,
        BR_BGEU = 4'd6,
        BR_JAL  = 4'd7,
        BR_JALR = 4'd8
    } br_type_e;

    typedef enum logic {
        EXU_EMPTY = 1'b0,
        EXU_FULL  = 1'b1
    } exu_state_e;

endpackage

// File: rtl/ysyx_22041211_exu_alu.sv
// rtl/ysyx_22041211_exu_alu.sv - combinational ALU with zero and less-than flags for branch resolution
module ysyx_22041211_ALU
    import ysyx_22041211_exu_pkg::*;
#(
    parameter int DATA_LEN = 32
) (
    input  logic [DATA_LEN-1:0] alu_a_i,
    input  logic [DATA_LEN-1:0] alu_b_i,
    input  logic [3:0]          alu_ctrl_i,
    output logic [DATA_LEN-1:0] alu_result_o,
    output logic                alu_zero_o,
    output logic                alu_less_o
);

    localparam int SHAMT_W = $clog2(DATA_LEN);

    logic [SHAMT_W-1:0] shamt;
    logic               less_signed;
    logic               less_unsigned;

    assign shamt         = alu_b_i[SHAMT_W-1:0];
    assign less_signed   = $signed(alu_a_i) < $signed(alu_b_i);
    assign less_unsigned = alu_a_i < alu_b_i;

    // The less flag follows the requested signedness so BLTU/BGEU reuse the same wire.
    assign alu_less_o = (alu_ctrl_i == ALU_OP_LESS_UNSIGNED) ? less_unsigned : less_signed;
    assign alu_zero_o = (alu_result_o == '0);

    always_comb begin
        alu_result_o = '0;
        case (alu_ctrl_i)
            ALU_OP_ADD:           alu_result_o = alu_a_i + alu_b_i;
            ALU_OP_SUB:           alu_result_o = alu_a_i - alu_b_i;
            ALU_OP_AND:           alu_result_o = alu_a_i & alu_b_i;
            ALU_OP_OR:            alu_result_o = alu_a_i | alu_b_i;
            ALU_OP_XOR:           alu_result_o = alu_a_i ^ alu_b_i;
            ALU_OP_SLL:           alu_result_o = alu_a_i << shamt;
            ALU_OP_SRL:           alu_result_o = alu_a_i >> shamt;
            ALU_OP_SRA:           alu_result_o = DATA_LEN'($signed(alu_a_i) >>> shamt);
            ALU_OP_LESS_SIGNED:   alu_result_o = {{(DATA_LEN-1){1'b0}}, less_signed};
            ALU_OP_LESS_UNSIGNED: alu_result_o = {{(DATA_LEN-1){1'b0}}, less_unsigned};
            default:              alu_result_o = '0;
        endcase
    end

endmodule

// File: rtl/ysyx_22041211_exu.sv
// rtl/ysyx_22041211_exu.sv - execute stage with one-entry output register; YSYX_22041211_EXU_PERF_EN adds perf counters
module ysyx_22041211_exu
    import ysyx_22041211_exu_pkg::*;
#(
    parameter int DATA_LEN = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  idu_valid_i,
    output logic                  exu_ready_o,
    input  logic [DATA_LEN-1:0]   pc_i,
    input  logic [DATA_LEN-1:0]   rs1_i,
    input  logic [DATA_LEN-1:0]   rs2_i,
    input  logic [DATA_LEN-1:0]   imm_i,
    input  logic [3:0]            alu_ctrl_i,
    input  logic [1:0]            src1_sel_i,
    input  logic [1:0]            src2_sel_i,
    input  logic [3:0]            br_type_i,
    input  logic [REG_ADDR_W-1:0] rd_i,
    input  logic                  wen_i,
    input  logic [MEM_OP_W-1:0]   mem_op_i,
    output logic                  exu_valid_o,
    input  logic                  lsu_ready_i,
    output logic [DATA_LEN-1:0]   result_o,
    output logic [DATA_LEN-1:0]   store_data_o,
    output logic [REG_ADDR_W-1:0] rd_o,
    output logic                  wen_o,
    output logic [MEM_OP_W-1:0]   mem_op_o,
    output logic                  redirect_o,
    output logic [DATA_LEN-1:0]   redirect_pc_o
`ifdef YSYX_22041211_EXU_PERF_EN
    ,
    output logic [31:0]           perf_stall_o,
    output logic [31:0]           perf_taken_o
`endif
);

    typedef struct packed {
        logic [DATA_LEN-1:0]   result;
        logic [DATA_LEN-1:0]   store_data;
        logic [REG_ADDR_W-1:0] rd;
        logic                  wen;
        logic [MEM_OP_W-1:0]   mem_op;
        logic [DATA_LEN-1:0]   redirect_pc;
    } exu_entry_t;

    exu_state_e          state_q, state_d;
    exu_entry_t          entry_q, entry_d;
    logic                redirect_q, redirect_d;

    logic                accept;
    logic [DATA_LEN-1:0] src1, src2;
    logic [DATA_LEN-1:0] alu_result;
    logic                alu_zero, alu_less;
    logic                taken;
    logic [DATA_LEN-1:0] br_target, jalr_sum, target;

    assign exu_valid_o = (state_q == EXU_FULL);
    assign exu_ready_o = !exu_valid_o || lsu_ready_i;
    assign accept      = idu_valid_i && exu_ready_o;

    always_comb begin
        src1 = '0;
        case (src1_sel_i)
            SRC1_RS1: src1 = rs1_i;
            SRC1_PC:  src1 = pc_i;
            default:  src1 = '0;
        endcase
        src2 = '0;
        case (src2_sel_i)
            SRC2_RS2:  src2 = rs2_i;
            SRC2_IMM:  src2 = imm_i;
            SRC2_FOUR: src2 = DATA_LEN'(4);
            default:   src2 = '0;
        endcase
    end

    ysyx_22041211_ALU #(
        .DATA_LEN (DATA_LEN)
    ) u_alu (
        .alu_a_i      (src1),
        .alu_b_i      (src2),
        .alu_ctrl_i   (alu_ctrl_i),
        .alu_result_o (alu_result),
        .alu_zero_o   (alu_zero),
        .alu_less_o   (alu_less)
    );

    // Targets use their own adders so the ALU stays free to produce pc+4 for links.
    assign br_target = pc_i + imm_i;
    assign jalr_sum  = rs1_i + imm_i;
    assign target    = (br_type_i == BR_JALR) ? {jalr_sum[DATA_LEN-1:1], 1'b0} : br_target;

    always_comb begin
        taken = 1'b0;
        case (br_type_i)
            BR_BEQ:           taken = alu_zero;
            BR_BNE:           taken = !alu_zero;
            BR_BLT, BR_BLTU:  taken = alu_less;
            BR_BGE, BR_BGEU:  taken = !alu_less;
            BR_JAL, BR_JALR:  taken = 1'b1;
            default:          taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        entry_d    = entry_q;
        redirect_d = 1'b0;
        if (accept) begin
            state_d             = EXU_FULL;
            entry_d.result      = alu_result;
            entry_d.store_data  = rs2_i;
            entry_d.rd          = rd_i;
            entry_d.wen         = wen_i;
            entry_d.mem_op      = mem_op_i;
            entry_d.redirect_pc = target;
            redirect_d          = taken;
        end else if (state_q == EXU_FULL && lsu_ready_i) begin
            state_d = EXU_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EXU_EMPTY;
            entry_q    <= '0;
            redirect_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            entry_q    <= entry_d;
            redirect_q <= redirect_d;
        end
    end

    assign result_o      = entry_q.result;
    assign store_data_o  = entry_q.store_data;
    assign rd_o          = entry_q.rd;
    assign wen_o         = entry_q.wen;
    assign mem_op_o      = entry_q.mem_op;
    assign redirect_o    = redirect_q;
    assign redirect_pc_o = entry_q.redirect_pc;

`ifdef YSYX_22041211_EXU_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_taken_q, perf_taken_d;

    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_taken_d = perf_taken_q;
        if (exu_valid_o && !lsu_ready_i && perf_stall_q != 32'hFFFF_FFFF) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
        if (redirect_q && perf_taken_q != 32'hFFFF_FFFF) begin
            perf_taken_d = perf_taken_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_q <= '0;
            perf_taken_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_taken_q <= perf_taken_d;
        end
    end

    assign perf_stall_o = perf_stall_q;
    assign perf_taken_o = perf_taken_q;
`endif

endmodule

// File: tb/tb_ysyx_22041211_exu.sv
// tb/tb_ysyx_22041211_exu.sv - vector table, corner sequences and randomized ISA-level model check of the EXU
module tb_ysyx_22041211_exu;
    import ysyx_22041211_exu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        idu_valid_i, exu_ready_o, exu_valid_o, lsu_ready_i;
    logic [31:0] pc_i, rs1_i, rs2_i, imm_i;
    logic [3:0]  alu_ctrl_i, br_type_i, mem_op_i, mem_op_o;
    logic [1:0]  src1_sel_i, src2_sel_i;
    logic [4:0]  rd_i, rd_o;
    logic        wen_i, wen_o, redirect_o;
    logic [31:0] result_o, store_data_o, redirect_pc_o;
`ifdef YSYX_22041211_EXU_PERF_EN
    logic [31:0] perf_stall_o, perf_taken_o;
`endif

    always #5 clk = ~clk;

    ysyx_22041211_exu dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .idu_valid_i   (idu_valid_i),
        .exu_ready_o   (exu_ready_o),
        .pc_i          (pc_i),
        .rs1_i         (rs1_i),
        .rs2_i         (rs2_i),
        .imm_i         (imm_i),
        .alu_ctrl_i    (alu_ctrl_i),
        .src1_sel_i    (src1_sel_i),
        .src2_sel_i    (src2_sel_i),
        .br_type_i     (br_type_i),
        .rd_i          (rd_i),
        .wen_i         (wen_i),
        .mem_op_i      (mem_op_i),
        .exu_valid_o   (exu_valid_o),
        .lsu_ready_i   (lsu_ready_i),
        .result_o      (result_o),
        .store_data_o  (store_data_o),
        .rd_o          (rd_o),
        .wen_o         (wen_o),
        .mem_op_o      (mem_op_o),
        .redirect_o    (redirect_o),
        .redirect_pc_o (redirect_pc_o)
`ifdef YSYX_22041211_EXU_PERF_EN
        ,
        .perf_stall_o  (perf_stall_o),
        .perf_taken_o  (perf_taken_o)
`endif
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    typedef struct {
        logic [31:0] pc, rs1, rs2, imm;
        logic [3:0]  alu;
        logic [1:0]  s1, s2;
        logic [3:0]  br;
        logic [4:0]  rd;
        logic        wen;
        logic [31:0] e_res;
        logic        e_redir;
        logic [31:0] e_tgt;
    } vec_t;

    typedef struct {
        logic [31:0] res, sd, tgt;
        logic [4:0]  rd;
        logic        wen, taken;
        logic [3:0]  mem;
    } exp_t;

    task automatic drive(input logic [31:0] pc, rs1, rs2, imm, input logic [3:0] alu,
                         input logic [1:0] s1, s2, input logic [3:0] br, input logic [4:0] rd,
                         input logic wen);
        pc_i = pc; rs1_i = rs1; rs2_i = rs2; imm_i = imm; alu_ctrl_i = alu;
        src1_sel_i = s1; src2_sel_i = s2; br_type_i = br; rd_i = rd; wen_i = wen; mem_op_i = 4'h0;
    endtask

    // Instruction-level reference: results come from RISC-V semantics, not from ALU flags.
    task automatic gen_random(output exp_t e);
        int          kind;
        logic [31:0] a, b, imm, pc, tmp;
        logic [4:0]  sh;
        kind = $urandom_range(0, 20);
        a    = $urandom;
        b    = ($urandom_range(0, 3) == 0) ? a : $urandom;
        imm  = $urandom;
        tmp  = $urandom;
        pc   = tmp & 32'hFFFF_FFFC;
        sh   = b[4:0];
        drive(pc, a, b, imm, ALU_OP_ADD, SRC1_RS1, SRC2_RS2, BR_NONE,
              5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
        mem_op_i = 4'($urandom_range(0, 15));
        e.taken = 1'b0;
        e.tgt   = pc + imm;
        e.res   = 32'h0;
        case (kind)
            0:  e.res = a + b;
            1:  begin alu_ctrl_i = ALU_OP_SUB; e.res = a - b; end
            2:  begin alu_ctrl_i = ALU_OP_AND; e.res = a & b; end
            3:  begin alu_ctrl_i = ALU_OP_OR;  e.res = a | b; end
            4:  begin alu_ctrl_i = ALU_OP_XOR; e.res = a ^ b; end
            5:  begin alu_ctrl_i = ALU_OP_SLL; e.res = a << sh; end
            6:  begin alu_ctrl_i = ALU_OP_SRL; e.res = a >> sh; end
            7:  begin alu_ctrl_i = ALU_OP_SRA; e.res = $signed(a) >>> sh; end
            8:  begin alu_ctrl_i = ALU_OP_LESS_SIGNED;   e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
            9:  begin alu_ctrl_i = ALU_OP_LESS_UNSIGNED; e.res = (a < b) ? 32'd1 : 32'd0; end
            10: begin src2_sel_i = SRC2_IMM; e.res = a + imm; end
            11, 12: begin
                alu_ctrl_i = ALU_OP_SUB; br_type_i = (kind == 11) ? BR_BEQ : BR_BNE; wen_i = 1'b0;
                e.res = a - b; e.taken = (kind == 11) ? (a == b) : (a != b);
            end
            13, 14: begin
                alu_ctrl_i = ALU_OP_LESS_SIGNED; br_type_i = (kind == 13) ? BR_BLT : BR_BGE; wen_i = 1'b0;
                e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                e.taken = (kind == 13) ? ($signed(a) < $signed(b)) : ($signed(a) >= $signed(b));
            end
            15, 16: begin
                alu_ctrl_i = ALU_OP_LESS_UNSIGNED; br_type_i = (kind == 15) ? BR_BLTU : BR_BGEU; wen_i = 1'b0;
                e.res = (a < b) ? 32'd1 : 32'd0;
                e.taken = (kind == 15) ? (a < b) : (a >= b);
            end
            17, 18: begin
                src1_sel_i = SRC1_PC; src2_sel_i = SRC2_FOUR; br_type_i = (kind == 17) ? BR_JAL : BR_JALR;
                e.res = pc + 32'd4; e.taken = 1'b1;
                if (kind == 18) e.tgt = (a + imm) & 32'hFFFF_FFFE;
            end
            19: begin src1_sel_i = SRC1_ZERO; src2_sel_i = SRC2_IMM; e.res = imm; end
            default: begin src1_sel_i = SRC1_PC; src2_sel_i = SRC2_IMM; e.res = pc + imm; end
        endcase
        e.sd = b; e.rd = rd_i; e.wen = wen_i; e.mem = mem_op_i;
    endtask

    vec_t vecs[10];
    exp_t nxt, m_ent;
    bit   m_valid, m_fresh, acc;

    initial begin
        vecs[0] = '{32'h0,        32'd5,        32'd7,        32'd0,        ALU_OP_ADD,           SRC1_RS1,  SRC2_RS2,  BR_NONE, 5'd3,  1'b1, 32'd12,       1'b0, 32'h0};
        vecs[1] = '{32'h100,      32'hFFFF_FFFF, 32'd1,       32'h20,       ALU_OP_LESS_SIGNED,   SRC1_RS1,  SRC2_RS2,  BR_BLT,  5'd0,  1'b0, 32'd1,        1'b1, 32'h120};
        vecs[2] = '{32'h100,      32'hFFFF_FFFF, 32'd1,       32'h20,       ALU_OP_LESS_UNSIGNED, SRC1_RS1,  SRC2_RS2,  BR_BLTU, 5'd0,  1'b0, 32'd0,        1'b0, 32'h0};
        vecs[3] = '{32'h200,      32'h8000_0003, 32'd0,       32'd2,        ALU_OP_ADD,           SRC1_PC,   SRC2_FOUR, BR_JALR, 5'd1,  1'b1, 32'h204,      1'b1, 32'h8000_0004};
        vecs[4] = '{32'h40,       32'd9,        32'd9,        32'hFFFF_FFF8, ALU_OP_SUB,          SRC1_RS1,  SRC2_RS2,  BR_BEQ,  5'd0,  1'b0, 32'd0,        1'b1, 32'h38};
        vecs[5] = '{32'h40,       32'd9,        32'd9,        32'hFFFF_FFF8, ALU_OP_SUB,          SRC1_RS1,  SRC2_RS2,  BR_BNE,  5'd0,  1'b0, 32'd0,        1'b0, 32'h0};
        vecs[6] = '{32'h1000,     32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'h10,     ALU_OP_LESS_SIGNED,   SRC1_RS1,  SRC2_RS2,  BR_BGE,  5'd0,  1'b0, 32'd0,        1'b1, 32'h1010};
        vecs[7] = '{32'h0,        32'h8000_0000, 32'd0,       32'h24,       ALU_OP_SRA,           SRC1_RS1,  SRC2_IMM,  BR_NONE, 5'd31, 1'b1, 32'hF800_0000, 1'b0, 32'h0};
        vecs[8] = '{32'hFFFF_FFFC, 32'd0,       32'd0,        32'd8,        ALU_OP_ADD,           SRC1_PC,   SRC2_FOUR, BR_JAL,  5'd1,  1'b1, 32'h0,        1'b1, 32'h4};
        vecs[9] = '{32'h0,        32'h1234,     32'd1,        32'd0,        ALU_OP_SUB,           SRC1_ZERO, SRC2_RS2,  BR_NONE, 5'd7,  1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0};

        rst_n = 1'b0; idu_valid_i = 1'b0; lsu_ready_i = 1'b1;
        drive(32'h0, 32'h0, 32'h0, 32'h0, ALU_OP_ADD, SRC1_RS1, SRC2_RS2, BR_NONE, 5'd0, 1'b0);
        @(negedge clk); @(negedge clk);
        check("rst_valid", {31'b0, exu_valid_o}, 32'd0);
        check("rst_redirect", {31'b0, redirect_o}, 32'd0);
        check("rst_result", result_o, 32'd0);
        check("rst_ready", {31'b0, exu_ready_o}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].pc, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, vecs[i].alu,
                  vecs[i].s1, vecs[i].s2, vecs[i].br, vecs[i].rd, vecs[i].wen);
            idu_valid_i = 1'b1; lsu_ready_i = 1'b1;
            @(negedge clk);
            check($sformatf("vec%0d_valid", i), {31'b0, exu_valid_o}, 32'd1);
            check($sformatf("vec%0d_result", i), result_o, vecs[i].e_res);
            check($sformatf("vec%0d_redirect", i), {31'b0, redirect_o}, {31'b0, vecs[i].e_redir});
            if (vecs[i].e_redir) check($sformatf("vec%0d_target", i), redirect_pc_o, vecs[i].e_tgt);
            check($sformatf("vec%0d_rd_wen", i), {26'b0, rd_o, wen_o}, {26'b0, vecs[i].rd, vecs[i].wen});
            check($sformatf("vec%0d_store", i), store_data_o, vecs[i].rs2);
            idu_valid_i = 1'b0;
            @(negedge clk);
            check($sformatf("vec%0d_drain", i), {31'b0, exu_valid_o}, 32'd0);
        end

        // Stall: a JAL sits in the register while LSU refuses and IDU keeps offering an ADD.
        drive(32'h300, 32'h0, 32'h0, 32'h10, ALU_OP_ADD, SRC1_PC, SRC2_FOUR, BR_JAL, 5'd1, 1'b1);
        idu_valid_i = 1'b1; lsu_ready_i = 1'b1;
        @(negedge clk);
        check("stall_first_redirect", {31'b0, redirect_o}, 32'd1);
        check("stall_first_target", redirect_pc_o, 32'h310);
        drive(32'h400, 32'd1, 32'd2, 32'h0, ALU_OP_ADD, SRC1_RS1, SRC2_RS2, BR_NONE, 5'd9, 1'b1);
        lsu_ready_i = 1'b0;
        #1 check("stall_ready_low", {31'b0, exu_ready_o}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("stall%0d_ready", k), {31'b0, exu_ready_o}, 32'd0);
            check($sformatf("stall%0d_valid", k), {31'b0, exu_valid_o}, 32'd1);
            check($sformatf("stall%0d_result", k), result_o, 32'h304);
            check($sformatf("stall%0d_target", k), redirect_pc_o, 32'h310);
            check($sformatf("stall%0d_redirect", k), {31'b0, redirect_o}, 32'd0);
        end
        lsu_ready_i = 1'b1;
        #1 check("stall_release_ready", {31'b0, exu_ready_o}, 32'd1);
        @(negedge clk);
        check("stall_new_result", result_o, 32'd3);
        check("stall_new_rd", {27'b0, rd_o}, 32'd9);
        check("stall_new_redirect", {31'b0, redirect_o}, 32'd0);
        idu_valid_i = 1'b0;
        @(negedge clk);

        // Asynchronous reset while FULL clears the entry before any clock edge.
        drive(32'h500, 32'h0, 32'h55, 32'h8, ALU_OP_ADD, SRC1_PC, SRC2_FOUR, BR_JAL, 5'd2, 1'b1);
        idu_valid_i = 1'b1;
        @(negedge clk);
        idu_valid_i = 1'b0; lsu_ready_i = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("areset_valid", {31'b0, exu_valid_o}, 32'd0);
        check("areset_result", result_o, 32'd0);
        check("areset_redirect", {31'b0, redirect_o}, 32'd0);
        check("areset_target", redirect_pc_o, 32'd0);
        check("areset_store", store_data_o, 32'd0);
        #1 rst_n = 1'b1;
        lsu_ready_i = 1'b1;
        @(negedge clk);
        drive(32'h0, 32'd5, 32'd7, 32'h0, ALU_OP_ADD, SRC1_RS1, SRC2_RS2, BR_NONE, 5'd3, 1'b1);
        idu_valid_i = 1'b1;
        @(negedge clk);
        check("post_reset_result", result_o, 32'd12);
        check("post_reset_valid", {31'b0, exu_valid_o}, 32'd1);
        idu_valid_i = 1'b0;
        @(negedge clk);

`ifdef YSYX_22041211_EXU_PERF_EN
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        check("perf_reset_stall", perf_stall_o, 32'd0);
        @(negedge clk);
        drive(32'h600, 32'h0, 32'h0, 32'h40, ALU_OP_ADD, SRC1_PC, SRC2_FOUR, BR_JAL, 5'd1, 1'b1);
        idu_valid_i = 1'b1; lsu_ready_i = 1'b1;
        @(negedge clk);
        idu_valid_i = 1'b0; lsu_ready_i = 1'b0;
        repeat (4) @(negedge clk);
        drive(32'h700, 32'd4, 32'd4, 32'h20, ALU_OP_SUB, SRC1_RS1, SRC2_RS2, BR_BEQ, 5'd0, 1'b0);
        idu_valid_i = 1'b1; lsu_ready_i = 1'b1;
        @(negedge clk);
        idu_valid_i = 1'b0;
        @(negedge clk); @(negedge clk);
        check("perf_stall", perf_stall_o, 32'd4);
        check("perf_taken", perf_taken_o, 32'd2);
`endif

        // Random stream with random backpressure against the one-entry model.
        m_valid = 1'b0; m_fresh = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            check("rnd_valid", {31'b0, exu_valid_o}, {31'b0, m_valid});
            if (m_valid) begin
                check("rnd_result", result_o, m_ent.res);
                check("rnd_store", store_data_o, m_ent.sd);
                check("rnd_ctl", {22'b0, rd_o, wen_o, mem_op_o}, {22'b0, m_ent.rd, m_ent.wen, m_ent.mem});
                check("rnd_redirect", {31'b0, redirect_o}, {31'b0, m_fresh && m_ent.taken});
                if (m_fresh && m_ent.taken) check("rnd_target", redirect_pc_o, m_ent.tgt);
            end else begin
                check("rnd_idle_redirect", {31'b0, redirect_o}, 32'd0);
            end
            lsu_ready_i = ($urandom_range(0, 3) != 0);
            idu_valid_i = ($urandom_range(0, 3) != 0);
            gen_random(nxt);
            #1 check("rnd_ready", {31'b0, exu_ready_o}, {31'b0, !m_valid || lsu_ready_i});
            acc = idu_valid_i && (!m_valid || lsu_ready_i);
            if (acc) begin
                m_ent = nxt; m_valid = 1'b1; m_fresh = 1'b1;
            end else begin
                m_fresh = 1'b0;
                if (m_valid && lsu_ready_i) m_valid = 1'b0;
            end
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
